wishbone_rr_arbiter: RTL and testbench

//   Shares one Wishbone B4 classic device among NUM_CTRL controllers.
//   - Round-robin grant; the owner keeps the bus for its whole cyc.
//   - Optional watchdog aborts a stalled cycle with a synthesised err.
//   - Sits between controller ports and a single device port of the

---
 rtl/wishbone_rr_arbiter_if.sv | 33 +++
 rtl/wishbone_rr_arbiter.sv | 97 +++++++++
 tb/tb_wishbone_rr_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/wishbone_rr_arbiter_if.sv
// wishbone_rr_arbiter_if: controller-side and device-side Wishbone classic signals of the arbiter
interface wishbone_rr_arbiter_if #(
    parameter int DAT_WIDTH = 8,
    parameter int NUM_CTRL  = 4
);
    logic [NUM_CTRL-1:0]           c_cyc_i;
    logic [NUM_CTRL-1:0]           c_stb_i;
    logic [NUM_CTRL-1:0]           c_we_i;
    logic [NUM_CTRL*DAT_WIDTH-1:0] c_dat_i;
    logic [NUM_CTRL-1:0]           c_ack_o;
    logic [NUM_CTRL-1:0]           c_err_o;
    logic [NUM_CTRL-1:0]           c_rty_o;
    logic [DAT_WIDTH-1:0]          c_dat_o;
    logic                          d_cyc_o;
    logic                          d_stb_o;
    logic                          d_we_o;
    logic [DAT_WIDTH-1:0]          d_dat_o;
    logic                          d_ack_i;
    logic                          d_err_i;
    logic                          d_rty_i;
    logic [DAT_WIDTH-1:0]          d_dat_i;
    logic [NUM_CTRL-1:0]           gnt_o;

    modport slave (
        input  c_cyc_i, c_stb_i, c_we_i, c_dat_i, d_ack_i, d_err_i, d_rty_i, d_dat_i,
        output c_ack_o, c_err_o, c_rty_o, c_dat_o, d_cyc_o, d_stb_o, d_we_o, d_dat_o, gnt_o
    );

    modport master (
        output c_cyc_i, c_stb_i, c_we_i, c_dat_i, d_ack_i, d_err_i, d_rty_i, d_dat_i,
        input  c_ack_o, c_err_o, c_rty_o, c_dat_o, d_cyc_o, d_stb_o, d_we_o, d_dat_o, gnt_o
    );
endinterface

// File: rtl/wishbone_rr_arbiter.sv
// wishbone_rr_arbiter: round-robin sharing of one Wishbone classic device with a stall watchdog
module wishbone_rr_arbiter #(
    parameter int DAT_WIDTH = 8,
    parameter int NUM_CTRL  = 4,
    parameter int TIMEOUT   = 16
) (
    input logic clk_i,
    input logic rst_i,
    wishbone_rr_arbiter_if.slave wb
);
    localparam int PW = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WLIM = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, OWN, ABORT} state_e;

    state_e              state_q, state_d;
    logic [NUM_CTRL-1:0] gnt_q, gnt_d;
    logic [PW-1:0]       ptr_q, ptr_d, own_q, own_d;
    logic [WW-1:0]       wdog_q, wdog_d;
    logic [PW-1:0]       win;
    logic                found;
    logic                sel_cyc, sel_stb, resp, timeout;

    // first requester at or after the round-robin pointer
    always_comb begin
        win = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (!found && wb.c_cyc_i[(int'(ptr_q) + i) % NUM_CTRL]) begin
                win = PW'((int'(ptr_q) + i) % NUM_CTRL);
                found = 1'b1;
            end
        end
    end

    assign sel_cyc = wb.c_cyc_i[own_q];
    assign sel_stb = wb.c_stb_i[own_q];
    assign resp    = wb.d_ack_i | wb.d_err_i | wb.d_rty_i;
    assign timeout = (TIMEOUT > 0) && (state_q == OWN) && sel_stb && !resp && (wdog_q == WLIM);
    assign wb.gnt_o = gnt_q;

    always_comb begin
        state_d = state_q;
        gnt_d = gnt_q;
        ptr_d = ptr_q;
        own_d = own_q;
        wdog_d = '0;
        wb.d_cyc_o = 1'b0;
        wb.d_stb_o = 1'b0;
        wb.d_we_o = 1'b0;
        wb.d_dat_o = '0;
        wb.c_dat_o = '0;
        wb.c_ack_o = '0;
        wb.c_err_o = '0;
        wb.c_rty_o = '0;
        if (state_q == IDLE && found) begin
            state_d = OWN;
            gnt_d = NUM_CTRL'(1) << win;
            own_d = win;
            ptr_d = (win == PW'(NUM_CTRL - 1)) ? '0 : win + 1'b1;
        end
        if (state_q == OWN) begin
            wb.d_cyc_o = sel_cyc;
            wb.d_stb_o = sel_stb;
            wb.d_we_o = wb.c_we_i[own_q];
            wb.d_dat_o = wb.c_dat_i[int'(own_q)*DAT_WIDTH +: DAT_WIDTH];
            wb.c_dat_o = wb.d_dat_i;
            wb.c_ack_o[own_q] = wb.d_ack_i & sel_cyc & sel_stb;
            wb.c_err_o[own_q] = (wb.d_err_i | timeout) & sel_cyc & sel_stb;
            wb.c_rty_o[own_q] = wb.d_rty_i & sel_cyc & sel_stb;
            wdog_d = (TIMEOUT > 0 && sel_stb && !resp && !timeout) ? wdog_q + 1'b1 : '0;
            state_d = !sel_cyc ? IDLE : timeout ? ABORT : OWN;
            gnt_d = !sel_cyc ? '0 : gnt_q;
        end
        if (state_q == ABORT) begin
            state_d = sel_cyc ? ABORT : IDLE;
            gnt_d = sel_cyc ? gnt_q : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q <= '0;
            ptr_q <= '0;
            own_q <= '0;
            wdog_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q <= gnt_d;
            ptr_q <= ptr_d;
            own_q <= own_d;
            wdog_q <= wdog_d;
        end
    end
endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// tb_wishbone_rr_arbiter: directed vector table plus watchdog corner sequences
module tb_wishbone_rr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    wishbone_rr_arbiter_if #(.DAT_WIDTH(8), .NUM_CTRL(4)) wb ();

    wishbone_rr_arbiter #(.DAT_WIDTH(8), .NUM_CTRL(4), .TIMEOUT(16)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .wb(wb)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  cyc, stb, we;
        logic [31:0] dat;
        logic [2:0]  rsp;
        logic [3:0]  gnt;
        logic [2:0]  d;
        logic [7:0]  ddat;
        logic [3:0]  cack, cerr, crty;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input int rst, cyc, stb, we, input logic [31:0] dat,
                               input int rsp, gnt, d, ddat, cack, cerr, crty);
        vec_t r;
        r.rst = 1'(rst);
        r.cyc = 4'(cyc);
        r.stb = 4'(stb);
        r.we = 4'(we);
        r.dat = dat;
        r.rsp = 3'(rsp);
        r.gnt = 4'(gnt);
        r.d = 3'(d);
        r.ddat = 8'(ddat);
        r.cack = 4'(cack);
        r.cerr = 4'(cerr);
        r.crty = 4'(crty);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] cyc, input logic [3:0] stb, input logic [2:0] rsp);
        wb.c_cyc_i = cyc;
        wb.c_stb_i = stb;
        {wb.d_ack_i, wb.d_err_i, wb.d_rty_i} = rsp;
    endtask

    task automatic restart();
        rst = 1'b1;
        drive(4'h0, 4'h0, 3'b000);
        @(negedge clk);
        rst = 1'b0;
    endtask

    localparam logic [31:0] D = 32'h44332211;

    initial begin
        wb.c_we_i = '0;
        wb.c_dat_i = '0;
        wb.d_dat_i = 8'h5A;
        drive(4'h0, 4'h0, 3'b000);
        repeat (3) @(negedge clk);
        #1 chk("reset", 64'({wb.gnt_o, wb.d_cyc_o, wb.d_stb_o, wb.c_ack_o, wb.c_err_o, wb.c_dat_o}), 64'(0));
        // single transfer from c0
        vecs.push_back(v(0, 1, 1, 1, 'hA5, 0, 0, 0, 'h00, 0, 0, 0));
        vecs.push_back(v(0, 1, 1, 1, 'hA5, 0, 1, 7, 'hA5, 0, 0, 0));
        vecs.push_back(v(0, 1, 1, 1, 'hA5, 0, 1, 7, 'hA5, 0, 0, 0));
        vecs.push_back(v(0, 1, 1, 1, 'hA5, 4, 1, 7, 'hA5, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 'hA5, 0, 1, 0, 'hA5, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 'hA5, 0, 0, 0, 'h00, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 'h00, 0, 0, 0));
        // round robin 0,1,2,3,0
        vecs.push_back(v(0, 'hF, 'hF, 0, D, 0, 0, 0, 'h00, 0, 0, 0));
        vecs.push_back(v(0, 'hF, 'hF, 0, D, 4, 1, 6, 'h11, 1, 0, 0));
        vecs.push_back(v(0, 'hE, 'hE, 0, D, 0, 1, 0, 'h11, 0, 0, 0));
        vecs.push_back(v(0, 'hE, 'hE, 0, D, 0, 0, 0, 'h00, 0, 0, 0));
        vecs.push_back(v(0, 'hE, 'hE, 0, D, 4, 2, 6, 'h22, 2, 0, 0));
        vecs.push_back(v(0, 'hD, 'hD, 0, D, 0, 2, 0, 'h22, 0, 0, 0));
        vecs.push_back(v(0, 'hD, 'hD, 0, D, 0, 0, 0, 'h00, 0, 0, 0));
        vecs.push_back(v(0, 'hD, 'hD, 0, D, 4, 4, 6, 'h33, 4, 0, 0));
        vecs.push_back(v(0, 'hB, 'hB, 0, D, 0, 4, 0, 'h33, 0, 0, 0));
        vecs.push_back(v(0, 'hB, 'hB, 0, D, 0, 0, 0, 'h00, 0, 0, 0));
        vecs.push_back(v(0, 'hB, 'hB, 0, D, 4, 8, 6, 'h44, 8, 0, 0));
        vecs.push_back(v(0, 7, 7, 0, D, 0, 8, 0, 'h44, 0, 0, 0));
        vecs.push_back(v(0, 7, 7, 0, D, 0, 0, 0, 'h00, 0, 0, 0));
        vecs.push_back(v(0, 7, 7, 0, D, 0, 1, 6, 'h11, 0, 0, 0));
        vecs.push_back(v(0, 6, 6, 0, D, 0, 1, 0, 'h11, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, D, 0, 0, 0, 'h00, 0, 0, 0));
        // fairness: c2 owns, then c0+c3 request together
        vecs.push_back(v(0, 4, 4, 0, D, 0, 0, 0, 'h00, 0, 0, 0));
        vecs.push_back(v(0, 4, 4, 0, D, 4, 4, 6, 'h33, 4, 0, 0));
        vecs.push_back(v(0, 9, 9, 0, D, 0, 4, 0, 'h33, 0, 0, 0));
        vecs.push_back(v(0, 9, 9, 0, D, 0, 0, 0, 'h00, 0, 0, 0));
        vecs.push_back(v(0, 9, 9, 0, D, 4, 8, 6, 'h44, 8, 0, 0));
        vecs.push_back(v(0, 1, 1, 0, D, 0, 8, 0, 'h44, 0, 0, 0));
        vecs.push_back(v(0, 1, 1, 0, D, 0, 0, 0, 'h00, 0, 0, 0));
        vecs.push_back(v(0, 1, 1, 0, D, 4, 1, 6, 'h11, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, D, 0, 1, 0, 'h11, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, D, 0, 0, 0, 'h00, 0, 0, 0));
        // reset while c1 owns, then c0 wins from ptr 0; err+rty forwarded
        vecs.push_back(v(0, 2, 2, 2, D, 0, 0, 0, 'h00, 0, 0, 0));
        vecs.push_back(v(0, 2, 2, 2, D, 0, 2, 7, 'h22, 0, 0, 0));
        vecs.push_back(v(1, 2, 2, 2, D, 0, 2, 7, 'h22, 0, 0, 0));
        vecs.push_back(v(0, 3, 3, 0, D, 0, 0, 0, 'h00, 0, 0, 0));
        vecs.push_back(v(0, 3, 3, 0, D, 3, 1, 6, 'h11, 0, 1, 1));
        vecs.push_back(v(0, 0, 0, 0, D, 0, 1, 0, 'h11, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, D, 0, 0, 0, 'h00, 0, 0, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst;
            wb.c_we_i = vecs[i].we;
            wb.c_dat_i = vecs[i].dat;
            drive(vecs[i].cyc, vecs[i].stb, vecs[i].rsp);
            #1 chk($sformatf("vec%0d", i),
                   64'({wb.gnt_o, wb.d_cyc_o, wb.d_stb_o, wb.d_we_o, wb.d_dat_o,
                        wb.c_ack_o, wb.c_err_o, wb.c_rty_o, wb.c_dat_o}),
                   64'({vecs[i].gnt, vecs[i].d, vecs[i].ddat, vecs[i].cack, vecs[i].cerr,
                        vecs[i].crty, (vecs[i].gnt != 4'h0) ? 8'h5A : 8'h00}));
        end

        // watchdog: device never answers
        wb.c_we_i = '0;
        restart();
        drive(4'h1, 4'h1, 3'b000);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            #1 chk($sformatf("wd_wait%0d", k), 64'({wb.d_stb_o, wb.c_err_o}), 64'({1'b1, 4'h0}));
        end
        @(negedge clk);
        #1 chk("wd_err", 64'({wb.d_stb_o, wb.c_err_o, wb.gnt_o}), 64'({1'b1, 4'h1, 4'h1}));
        @(negedge clk);
        drive(4'h1, 4'h1, 3'b100);
        #1 chk("wd_abort", 64'({wb.d_cyc_o, wb.d_stb_o, wb.c_ack_o, wb.c_err_o, wb.gnt_o}),
               64'({1'b0, 1'b0, 4'h0, 4'h0, 4'h1}));
        @(negedge clk);
        drive(4'h0, 4'h0, 3'b000);
        #1 chk("wd_drop", 64'(wb.gnt_o), 64'(4'h1));
        @(negedge clk);
        #1 chk("wd_idle", 64'({wb.gnt_o, wb.d_cyc_o}), 64'(0));

        // response in the timeout cycle wins
        restart();
        drive(4'h1, 4'h1, 3'b000);
        repeat (15) @(negedge clk);
        @(negedge clk);
        drive(4'h1, 4'h1, 3'b100);
        #1 chk("race_ack", 64'({wb.c_ack_o, wb.c_err_o}), 64'({4'h1, 4'h0}));
        @(negedge clk);
        drive(4'h1, 4'h1, 3'b000);
        #1 chk("race_own", 64'({wb.gnt_o, wb.d_cyc_o, wb.d_stb_o, wb.c_err_o}),
               64'({4'h1, 1'b1, 1'b1, 4'h0}));
        @(negedge clk);
        drive(4'h0, 4'h0, 3'b000);
        @(negedge clk);
        #1 chk("race_idle", 64'({wb.gnt_o, wb.d_cyc_o}), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
